// File: rtl/alu_result_stage.sv
// alu_result_stage: captures shift/ALU results with carry, derives Z/N/C flags, and buffers two entries in FIFO order.
// Latency: a push into an empty buffer is visible on out_* the next cycle. There is no in->out bypass.
// Backpressure: in_ready = (occupancy < 2), from registered state only. Optional RESULT_HOLD_EN delays out_valid per new head.
module alu_result_stage #(
  parameter int WIDTH       = 3,
  parameter int DEPTH       = 2,
  parameter int HOLD_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_result,
  input  logic             in_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_z,
  output logic             out_n,
  output logic             out_c,
  output logic [7:0]       out_count
);

  // Two entry registers; flags are frozen at push time.
  logic [WIDTH-1:0] res_q [2];
  logic             z_q   [2];
  logic             n_q   [2];
  logic             c_q   [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       occ;
  logic             push;
  logic             pop;
  logic             has_head;
  logic             head_ok;

  assign has_head = (occ != 2'd0);
  assign in_ready = (occ != 2'd2);
  assign push     = in_valid & in_ready;
  assign pop      = out_valid & out_ready;

`ifdef RESULT_HOLD_EN
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  logic [HW-1:0] hold_q;
  logic          new_head;

  // A new head appears on a push into empty, or on a pop that leaves an entry behind.
  assign new_head = (push & (occ == 2'd0)) | (pop & ((occ == 2'd2) | push));

  // Head hold counter: reload on each new head, then count down to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
    end else if (new_head) begin
      hold_q <= HW'(HOLD_CYCLES);
    end else if (hold_q != '0) begin
      hold_q <= hold_q - 1'b1;
    end
  end

  assign head_ok = (hold_q == '0);
`else
  assign head_ok = 1'b1;
`endif

  assign out_valid = has_head & head_ok;

  // Write the incoming result and its flags into the slot at the write pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        res_q[i] <= '0;
        z_q[i]   <= 1'b0;
        n_q[i]   <= 1'b0;
        c_q[i]   <= 1'b0;
      end
    end else if (push) begin
      res_q[wr_ptr] <= in_result;
      z_q[wr_ptr]   <= (in_result == '0);
      n_q[wr_ptr]   <= in_result[WIDTH-1];
      c_q[wr_ptr]   <= in_carry;
    end
  end

  // Pointer and occupancy bookkeeping; push+pop together leaves occupancy unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      if (push && !pop)      occ <= occ + 2'd1;
      else if (pop && !push) occ <= occ - 2'd1;
    end
  end

  // Debug count of completed output handshakes, wrapping at 256.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_count <= 8'd0;
    end else if (pop) begin
      out_count <= out_count + 8'd1;
    end
  end

  // Head data and flags are forced to zero while the buffer is empty.
  always_comb begin
    out_result = '0;
    out_z      = 1'b0;
    out_n      = 1'b0;
    out_c      = 1'b0;
    if (has_head) begin
      out_result = res_q[rd_ptr];
      out_z      = z_q[rd_ptr];
      out_n      = n_q[rd_ptr];
      out_c      = c_q[rd_ptr];
    end
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// Bench for alu_result_stage: directed steps from the test plan followed by random traffic.
// Reference model is a queue of {carry,result} plus a delivered-count integer.
// Build with RESULT_HOLD_EN defined to also exercise the head hold delay.
module tb_alu_result_stage;
  localparam int W    = 3;
  localparam int HOLD = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_result;
  logic         in_carry;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_result;
  logic         out_z;
  logic         out_n;
  logic         out_c;
  logic [7:0]   out_count;

  alu_result_stage #(.WIDTH(W), .DEPTH(2), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result), .in_carry(in_carry),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_z(out_z), .out_n(out_n), .out_c(out_c), .out_count(out_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [W:0] q[$];
  int         cnt  = 0;
  int         hold = 0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic model_valid();
    return (q.size() > 0) && (hold == 0);
  endfunction

  task automatic check_outputs();
    logic [W-1:0] r;
    logic         c;
    logic         have;
    have = (q.size() > 0);
    r = have ? q[0][W-1:0] : '0;
    c = have ? q[0][W] : 1'b0;
    check("out_valid",  8'(out_valid),  8'(model_valid()));
    check("out_result", 8'(out_result), 8'(r));
    check("out_z",      8'(out_z),      8'(have && (r == 0)));
    check("out_n",      8'(out_n),      8'(have && r[W-1]));
    check("out_c",      8'(out_c),      8'(c));
    check("in_ready",   8'(in_ready),   8'(q.size() < 2));
    check("out_count",  out_count,      8'(cnt % 256));
  endtask

  task automatic model_step(input logic v, input logic [W-1:0] r, input logic c, input logic ordy);
    int   sz0;
    logic psh;
    logic pp;
    logic nh;
    sz0 = q.size();
    psh = v && (sz0 < 2);
    pp  = model_valid() && ordy;
    if (pp) begin
      void'(q.pop_front());
      cnt++;
    end
    if (psh) q.push_back({c, r});
`ifdef RESULT_HOLD_EN
    nh = (psh && sz0 == 0) || (pp && (sz0 == 2 || psh));
    if (nh) hold = HOLD;
    else if (hold > 0) hold--;
`else
    nh = 1'b0;
    hold = 0;
`endif
  endtask

  // One clock: check outputs at the falling edge, drive, let the rising edge happen, update the model.
  task automatic cycle(input logic v, input logic [W-1:0] r, input logic c, input logic ordy);
    check_outputs();
    in_valid = v; in_result = r; in_carry = c; out_ready = ordy;
    @(posedge clk);
    model_step(v, r, c, ordy);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    check("rst_valid", 8'(out_valid), 8'd0);
    check("rst_count", out_count, 8'd0);
    check("rst_result", 8'(out_result), 8'd0);
    q.delete(); cnt = 0; hold = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    logic         pv;
    logic [W-1:0] pr;
    logic         pc;
    logic         acc;
    rst_n = 1'b0; in_valid = 1'b0; in_result = '0; in_carry = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    do_reset();
    check("reset_in_ready", 8'(in_ready), 8'd1);

    // 1: single push then pop
    cycle(1'b1, 3'b001, 1'b1, 1'b1);
    n = 0;
    while (!model_valid() && n < 20) begin cycle(1'b0, '0, 1'b0, 1'b1); n++; end
    check("t1_head", {4'd0, out_c, out_result}, {4'd0, 1'b1, 3'b001});
    cycle(1'b0, '0, 1'b0, 1'b1);
    check("t1_count", out_count, 8'd1);
    check("t1_empty", 8'(out_valid), 8'd0);

    // 2: zero then negative flags, in order
    cycle(1'b1, 3'b000, 1'b0, 1'b1);
    cycle(1'b1, 3'b100, 1'b0, 1'b1);
    for (int i = 0; i < 12; i++) cycle(1'b0, '0, 1'b0, 1'b1);

    // 3: backpressure with a rejected third offer
    cycle(1'b1, 3'b011, 1'b0, 1'b0);
    cycle(1'b1, 3'b101, 1'b1, 1'b0);
    check("t3_full", 8'(in_ready), 8'd0);
    cycle(1'b1, 3'b111, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) cycle(1'b0, '0, 1'b0, 1'b1);

    // 4: push and pop together at occupancy 1
    cycle(1'b1, 3'b010, 1'b0, 1'b0);
    n = 0;
    while (!model_valid() && n < 20) begin cycle(1'b0, '0, 1'b0, 1'b0); n++; end
    cycle(1'b1, 3'b110, 1'b0, 1'b1);
    check("t4_result", 8'(out_result), 8'(3'b110));
    for (int i = 0; i < 12; i++) cycle(1'b0, '0, 1'b0, 1'b1);

    // 5: asynchronous reset with two entries buffered and count at 5
    do_reset();
    n = 0;
    while (cnt < 5 && n < 200) begin cycle(1'b1, W'($urandom), 1'(($urandom)), 1'b1); n++; end
    n = 0;
    while (q.size() < 2 && n < 20) begin cycle(1'b1, 3'b011, 1'b0, 1'b0); n++; end
    check("t5_count", out_count, 8'd5);
    #3;
    rst_n = 1'b0;
    #1;
    check("t5_async_valid", 8'(out_valid), 8'd0);
    check("t5_async_count", out_count, 8'd0);
    q.delete(); cnt = 0; hold = 0;
    @(negedge clk);
    rst_n = 1'b1;
    check("t5_in_ready", 8'(in_ready), 8'd1);

`ifdef RESULT_HOLD_EN
    // head hold: out_valid rises HOLD cycles after the head is loaded
    cycle(1'b1, 3'b101, 1'b0, 1'b0);
    n = 0;
    while (!out_valid && n < 20) begin cycle(1'b0, '0, 1'b0, 1'b0); n++; end
    check("hold_delay", 8'(n), 8'(HOLD));
    for (int i = 0; i < 12; i++) cycle(1'b0, '0, 1'b0, 1'b1);
`endif

    // 6: counter wrap after 256 pops from reset
    do_reset();
    n = 0;
    while (cnt < 256 && n < 4000) begin cycle(1'b1, W'($urandom), 1'(($urandom)), 1'b1); n++; end
    check("t6_reached", 8'(cnt == 256), 8'd1);
    check("t6_wrap", out_count, 8'd0);

    // random traffic, producer holds an unaccepted offer stable
    pv = 1'b0; pr = '0; pc = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (!pv) begin
        pv = ($urandom_range(0, 99) < 60);
        pr = W'($urandom);
        pc = 1'($urandom);
      end
      acc = pv && (q.size() < 2);
      cycle(pv, pr, pc, ($urandom_range(0, 99) < 50));
      if (acc) pv = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
